// File: rtl/npu_mem_pkg.sv
// Shared constants and types for the NPU feature-map TDP RAM ports.
// Define TDP_OUT_REG_EN when the RAM macro's output register is enabled.
package npu_mem_pkg;

    localparam int TDP_ADDR_W = 15;
    localparam int TDP_DATA_W = 16;

    typedef enum logic {
        GNT_WRITE,
        GNT_READ
    } grant_e;

    // Cycles from address presentation to usable ram_dout.
`ifdef TDP_OUT_REG_EN
    localparam int TDP_RD_LAT = 2;
`else
    localparam int TDP_RD_LAT = 1;
`endif

endpackage

// File: rtl/tdp_rsp_fifo.sv
// Read-response FIFO: DATA_W x DEPTH, simultaneous push and pop honoured.
module tdp_rsp_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          data_i,
    input  logic                       pop_i,
    output logic [DATA_W-1:0]          data_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_pop  = pop_i && !empty_o;
    // Zero while empty so the response bus idles at a known value.
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/tdp_port_master.sv
// Initiator for one TDP RAM port: arbitrates write/read requests onto the port
// and returns read data through a credit-protected FIFO (see TDP_OUT_REG_EN).
module tdp_port_master
    import npu_mem_pkg::*;
#(
    parameter int ADDR_W    = TDP_ADDR_W,
    parameter int DATA_W    = TDP_DATA_W,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy
);

    localparam int PIPE_N = TDP_RD_LAT + 1;
    localparam int CNT_W  = $clog2(RSP_DEPTH) + 1;
    localparam int CRD_W  = CNT_W + 2;

    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_din_q, ram_din_d;
    logic [PIPE_N-1:0] pipe_q, pipe_d;
    grant_e            last_q, last_d;

    logic              rsp_push, rsp_pop, rd_cap;
    logic              fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [CRD_W-1:0]  inflight, credit_used;

    assign rsp_pop  = rsp_valid && rsp_ready;
    assign rsp_push = pipe_q[PIPE_N-1];

    // A read is only taken if its data is guaranteed a FIFO slot on arrival.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < PIPE_N; i++) begin
            inflight = inflight + CRD_W'(pipe_q[i]);
        end
        credit_used = inflight + CRD_W'(fifo_count) - CRD_W'(rsp_pop);
        rd_cap      = (credit_used < CRD_W'(RSP_DEPTH));
    end

    always_comb begin
        wr_ready   = 1'b0;
        rd_ready   = 1'b0;
        last_d     = last_q;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        pipe_d     = {pipe_q[PIPE_N-2:0], 1'b0};
        if (rst_n) begin
            if (wr_valid && rd_valid && rd_cap) begin
                if (last_q == GNT_READ) begin
                    wr_ready = 1'b1;
                    last_d   = GNT_WRITE;
                end else begin
                    rd_ready = 1'b1;
                    last_d   = GNT_READ;
                end
            end else if (wr_valid) begin
                // Out of read credits: the write proceeds without taking the turn.
                wr_ready = 1'b1;
                if (!rd_valid) begin
                    last_d = GNT_WRITE;
                end
            end else if (rd_valid && rd_cap) begin
                rd_ready = 1'b1;
                last_d   = GNT_READ;
            end
        end
        if (wr_ready) begin
            ram_we_d   = 1'b1;
            ram_addr_d = wr_addr;
            ram_din_d  = wr_data;
        end else if (rd_ready) begin
            ram_addr_d = rd_addr;
            pipe_d[0]  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            pipe_q     <= '0;
            last_q     <= GNT_READ;
        end else begin
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            pipe_q     <= pipe_d;
            last_q     <= last_d;
        end
    end

    tdp_rsp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (rsp_push),
        .data_i  (ram_dout),
        .pop_i   (rsp_pop),
        .data_o  (rsp_data),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assert property (@(posedge clk) disable iff (!rst_n)
        !(rsp_push && fifo_full && !rsp_pop));

    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_din   = ram_din_q;
    assign rsp_valid = !fifo_empty;
    assign busy      = (inflight != '0) || !fifo_empty;

endmodule

// File: doc/tdp_port_master.md
Name: tdp_port_master

Overview:
- Initiator side of one port of the dual-port feature-map RAM (dummy_tdp-style: 15-bit address, 16-bit data, synchronous read).
- Takes independent write-request and read-request streams (valid/ready) and arbitrates them onto a single RAM port.
- Returns read data on a valid/ready response stream, buffered so consumer backpressure never drops RAM data.
- Two instances, one per RAM port (a/b), sit between the NPU datapath and the TDP macro.

Parameters:
- ADDR_W, 15, RAM address width.
- DATA_W, 16, RAM data width.
- RSP_DEPTH, 4, response FIFO depth; power of two, minimum 2.

Ports:
- clk  in  1  port clock; the same clock drives the RAM port clka/clkb.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  write request valid.
- wr_ready  out  1  write request accepted this cycle.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rd_valid  in  1  read request valid.
- rd_ready  out  1  read request accepted this cycle.
- rd_addr  in  ADDR_W  read address.
- rsp_valid  out  1  read response valid.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  DATA_W  read response data.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_din  out  DATA_W  RAM write data.
- ram_dout  in  DATA_W  RAM read data.
- busy  out  1  high while any read is in flight or the FIFO is non-empty.

Behaviour:
- Reset (rst_n low, asynchronous): ram_we=0, ram_addr=0, ram_din=0, rsp_valid=0, rsp_data=0, busy=0. wr_ready and rd_ready are forced 0. FIFO is emptied, in-flight pipe is cleared, last_grant=READ.
- Issue: at most one RAM operation per cycle. ram_we/ram_addr/ram_din are registered and driven the cycle after acceptance. The port idles at we=0 with the address held.
- Credits: rd_cap = (inflight + fifo_count + rsp_pop_this_cycle_adjust) < RSP_DEPTH. inflight counts issued reads whose data has not yet been captured.
- Arbiter:
  - Only wr_valid: wr_ready=1.
  - Only rd_valid and rd_cap: rd_ready=1.
  - Both valid and rd_cap: grant the opposite of last_grant (round-robin). After reset, write wins first.
  - Both valid and !rd_cap: write is granted and last_grant is unchanged.
- Read latency: read accepted in cycle T, RAM address presented at T+1, ram_dout sampled at T+2. The data enters the FIFO and rsp_valid rises at T+3 if the FIFO was empty (capture register to FIFO is fall-through).
- Ordering:
  - Responses return in request order.
  - A read accepted the cycle after a write to the same address returns the new data, because the write commits at T+1 before the read address is presented at T+2.
- Response stream: rsp_data is stable while rsp_valid && !rsp_ready. Pop occurs when rsp_valid && rsp_ready. FIFO push and pop in the same cycle are both honoured.
- FIFO full: guaranteed never to overflow by the credit check. An overflow push is an assertion failure.
- Reset mid-operation: in-flight reads are discarded and no response is produced for them.
- busy = (inflight != 0) || (fifo_count != 0).

Optional Feature:
- Macro: TDP_OUT_REG_EN.
- Defined: the RAM output register is enabled and ram_dout is sampled one cycle later (read accepted at T, sampled at T+3). The in-flight pipe gains one stage, and the credit count includes that stage.
- Undefined: latency as in Behaviour.

Decomposition:
- Package npu_mem_pkg holds:
  - Constants TDP_ADDR_W=15 and TDP_DATA_W=16.
  - Grant enum {GNT_WRITE, GNT_READ}.
  - Localparam TDP_RD_LAT (1, or 2 with TDP_OUT_REG_EN).
- One sub-module, tdp_rsp_fifo: synchronous FIFO, DATA_W x RSP_DEPTH, with push/pop/count/full/empty and async active-low reset.

Test Plan:
- Write 232 to addr 10, then 332 to addr 9, then read 10 and 9 back-to-back with rsp_ready=1. Expect ram_we pulses on two cycles, rsp_data 232 then 332, first rsp_valid 3 cycles after the first rd_ready.
- wr_valid and rd_valid both held high for 6 cycles: grants alternate W,R,W,R,W,R starting with write. Responses arrive in order.
- rsp_ready=0 while issuing 6 reads to addrs 0..5 preloaded with 100..105: exactly RSP_DEPTH=4 are accepted, then rd_ready=0 with writes still accepted. Release rsp_ready: 100..103 return in order, then the remaining reads proceed.
- Write 0xBEEF to addr 0x7FFF, then read addr 0x7FFF next cycle: rsp_data=0xBEEF (top-of-range address, read-after-write).
- Assert rst_n low with 2 reads in flight and 1 response queued: all outputs reach reset values immediately, and no rsp_valid follows after rst_n rises.
- With TDP_OUT_REG_EN defined, repeat scenario 1: first rsp_valid arrives 4 cycles after the first rd_ready, with identical data.
